sdes_feistel_core: RTL and testbench
====================================

Name: sdes_feistel_core

Overview:
Iterative S-DES data-path core. It accepts one 8-bit block with two 8-bit subkeys and applies IP, fk(Ka), SW, fk(Kb), IP^-1. The result is returned over a valid/ready handshake. It sits between the key-schedule/host interface and the output register. It instantiates the team's 8-bit-in/4-bit-out S-box lookup inside its round function.

Parameters:
SBOX_REG, 0, 1 inserts a register after the S-box output, making each round 2 cycles.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input block and keys valid
in_ready  out  1  core can accept a block
in_data  in  8  plaintext or ciphertext block
decrypt  in  1  0 = use k1 then k2; 1 = use k2 then k1
k1  in  8  subkey K1
k2  in  8  subkey K2
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  8  result block, registered
busy  out  1  state is not IDLE
blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W

Behaviour:
- Bit numbering: permutation position 1 is bit 7 (MSB) and position 8 is bit 0.
- Permutation tables:
  - IP = 2 6 3 1 4 8 5 7
  - IP^-1 = 4 1 3 5 7 2 8 6
  - E/P (applied to the 4-bit R, position 1 = R[3]) = 4 1 2 3 2 3 4 1
  - P4 = 2 4 3 1
- Round function F(R,K):
  - x = EP(R) ^ K.
  - x drives the S-box; S0 uses x[7:4] and S1 uses x[3:0].
  - S-box row = {outer bits}, column = {inner bits}.
  - S-box output = {s0[1:0], s1[1:0]}, then P4.
- FSM states: IDLE, R1, R1X, R2, R2X, OUT. R1X and R2X exist only when SBOX_REG=1.
- IDLE:
  - in_ready=1.
  - On in_valid: {L,R} <= IP(in_data); ka <= decrypt?k2:k1; kb <= decrypt?k1:k2; go to R1.
  - Inputs other than in_valid are ignored outside an accept cycle.
- R1:
  - SBOX_REG=0: L <= R; R <= L^F(R,ka) (this includes SW); go to R2.
  - SBOX_REG=1: f_reg <= F-output; go to R1X. R1X applies the same update using f_reg, then goes to R2.
- R2 (and R2X when SBOX_REG=1):
  - L <= L^F(R,kb), with no swap.
  - out_data <= IP^-1({L',R}); go to OUT.
- OUT:
  - out_valid=1.
  - out_data holds stable while out_ready=0.
  - On out_ready: blk_count++, go to IDLE.
  - in_ready=0 in OUT; there is no overlap.
- Latency, accept edge to first cycle of out_valid:
  - 3 cycles for SBOX_REG=0.
  - 5 cycles for SBOX_REG=1.
  - Throughput is 1 block per (latency+1) cycles when out_ready=1.
- Simultaneous events: in_valid asserted during OUT is not accepted. It is accepted on the first IDLE cycle.
- blk_count wraps from all-ones to 0 with no flag.
- Reset, asynchronous at any time including mid-round:
  - state=IDLE; L, R, ka, kb, f_reg, out_data and blk_count clear to 0.
  - out_valid=0, busy=0, in_ready=1.
  - An in-flight block is discarded and no out_valid is produced for it.

Decomposition:
- Package sdes_pkg holds:
  - state enum
  - permutation functions ip, ip_inv, ep, p4
  - constants BLK_W=8 and HALF_W=4
- Sub-module sdes_fk: combinational F(R,K) covering EP, key XOR, S-box instance and P4. It is instantiated once and shared by both rounds through a ka/kb mux.

Test Plan:
1. Encrypt, SBOX_REG=0: in_data=8'b10010111, k1=8'b10100100, k2=8'b01000011, decrypt=0, out_ready=1 -> out_data=8'b00111000, out_valid exactly 3 cycles after the accept edge, blk_count=1.
2. Decrypt, same keys: in_data=8'b00111000, decrypt=1 -> out_data=8'b10010111.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable at 00111000; in_ready=0; in_valid held high is not accepted; one cycle after out_ready=1 the core accepts the next block.
4. SBOX_REG=1 rerun of tests 1 and 2 -> identical results, latency 5 cycles.
5. Reset mid-operation: assert rst while in R2 -> out_valid never asserts for that block; after release, in_ready=1 and blk_count=0; a new block gives the correct result.
6. Counter wrap with CNT_W=2: 5 back-to-back blocks, random keys checked against a reference model -> blk_count sequence 1,2,3,0,1; all outputs match the model.

Source files
------------

// File: rtl/sdes_pkg.sv
// Shared types, sizes and fixed bit permutations for the S-DES data path.
// Permutation position 1 is always the MSB of the operand.
package sdes_pkg;

    localparam int BLK_W  = 8;
    localparam int HALF_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R1,
        ST_R1X,
        ST_R2,
        ST_R2X,
        ST_OUT
    } state_t;

    // IP = 2 6 3 1 4 8 5 7
    function automatic logic [BLK_W-1:0] ip(input logic [BLK_W-1:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    // IP^-1 = 4 1 3 5 7 2 8 6
    function automatic logic [BLK_W-1:0] ip_inv(input logic [BLK_W-1:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    // E/P = 4 1 2 3 2 3 4 1, widening one half-block to a full round key width
    function automatic logic [BLK_W-1:0] ep(input logic [HALF_W-1:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    // P4 = 2 4 3 1
    function automatic logic [HALF_W-1:0] p4(input logic [HALF_W-1:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// Combinational S-DES round function F(R,K) = P4(S(EP(R) ^ K)).
// One instance is shared by both rounds; the caller muxes the key.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [HALF_W-1:0] r,
    input  logic [BLK_W-1:0]  key,
    output logic [HALF_W-1:0] f
);

    logic [BLK_W-1:0]  x;
    logic [HALF_W-1:0] s;

    assign x = ep(r) ^ key;

    sdes_sbox u_sbox (
        .x (x),
        .y (s)
    );

    assign f = p4(s);

endmodule

// File: rtl/sdes_sbox.sv
// Paired S-DES S-box lookup: S0 on x[7:4], S1 on x[3:0], output {s0, s1}.
// Row is the outer bit pair of each nibble, column the inner pair.
module sdes_sbox (
    input  logic [7:0] x,
    output logic [3:0] y
);

    logic [1:0] s0;
    logic [1:0] s1;

    // NOTE: default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        s0 = 2'd0;
        case ({x[7], x[4], x[6], x[5]})
            4'b0000: s0 = 2'd1;
            4'b0001: s0 = 2'd0;
            4'b0010: s0 = 2'd3;
            4'b0011: s0 = 2'd2;
            4'b0100: s0 = 2'd3;
            4'b0101: s0 = 2'd2;
            4'b0110: s0 = 2'd1;
            4'b0111: s0 = 2'd0;
            4'b1000: s0 = 2'd0;
            4'b1001: s0 = 2'd2;
            4'b1010: s0 = 2'd1;
            4'b1011: s0 = 2'd3;
            4'b1100: s0 = 2'd3;
            4'b1101: s0 = 2'd1;
            4'b1110: s0 = 2'd3;
            4'b1111: s0 = 2'd2;
            default: s0 = 2'd0;
        endcase
    end

    always_comb begin
        s1 = 2'd0;
        case ({x[3], x[0], x[2], x[1]})
            4'b0000: s1 = 2'd0;
            4'b0001: s1 = 2'd1;
            4'b0010: s1 = 2'd2;
            4'b0011: s1 = 2'd3;
            4'b0100: s1 = 2'd2;
            4'b0101: s1 = 2'd0;
            4'b0110: s1 = 2'd1;
            4'b0111: s1 = 2'd3;
            4'b1000: s1 = 2'd3;
            4'b1001: s1 = 2'd0;
            4'b1010: s1 = 2'd1;
            4'b1011: s1 = 2'd0;
            4'b1100: s1 = 2'd2;
            4'b1101: s1 = 2'd1;
            4'b1110: s1 = 2'd0;
            4'b1111: s1 = 2'd3;
            default: s1 = 2'd0;
        endcase
    end

    assign y = {s0, s1};

endmodule

// File: rtl/sdes_feistel_core.sv
// Iterative S-DES block core: IP, fk(ka), SW, fk(kb), IP^-1, one round per
// state (two when SBOX_REG=1), result held on a valid/ready output.
module sdes_feistel_core
    import sdes_pkg::*;
#(
    parameter int SBOX_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             decrypt,
    input  logic [BLK_W-1:0] k1,
    input  logic [BLK_W-1:0] k2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    state_t            state;
    logic [HALF_W-1:0] l_half;
    logic [HALF_W-1:0] r_half;
    logic [BLK_W-1:0]  ka;
    logic [BLK_W-1:0]  kb;
    logic [HALF_W-1:0] f_reg;
    logic [BLK_W-1:0]  k_round;
    logic [HALF_W-1:0] f_now;
    logic [HALF_W-1:0] f_use;
    logic [HALF_W-1:0] l_next;

    // Only R1 needs ka; in every other state the fk output is either unused or round 2.
    assign k_round = (state == ST_R1) ? ka : kb;

    sdes_fk u_fk (
        .r   (r_half),
        .key (k_round),
        .f   (f_now)
    );

    // The X states finish a round from the registered S-box result.
    assign f_use  = (state == ST_R1X || state == ST_R2X) ? f_reg : f_now;
    assign l_next = l_half ^ f_use;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            l_half    <= '0;
            r_half    <= '0;
            ka        <= '0;
            kb        <= '0;
            f_reg     <= '0;
            out_data  <= '0;
            blk_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_half, r_half} <= ip(in_data);
                        ka               <= decrypt ? k2 : k1;
                        kb               <= decrypt ? k1 : k2;
                        state            <= ST_R1;
                    end
                end

                // Round 1 includes the SW: halves cross over as they are updated.
                ST_R1: begin
                    if (SBOX_REG != 0) begin
                        f_reg <= f_now;
                        state <= ST_R1X;
                    end else begin
                        l_half <= r_half;
                        r_half <= l_next;
                        state  <= ST_R2;
                    end
                end

                ST_R1X: begin
                    l_half <= r_half;
                    r_half <= l_next;
                    state  <= ST_R2;
                end

                ST_R2: begin
                    if (SBOX_REG != 0) begin
                        f_reg <= f_now;
                        state <= ST_R2X;
                    end else begin
                        l_half   <= l_next;
                        out_data <= ip_inv({l_next, r_half});
                        state    <= ST_OUT;
                    end
                end

                ST_R2X: begin
                    l_half   <= l_next;
                    out_data <= ip_inv({l_next, r_half});
                    state    <= ST_OUT;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        blk_count <= blk_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_feistel_core.sv
// Bench for sdes_feistel_core: two instances (SBOX_REG=0 with CNT_W=2, SBOX_REG=1 with CNT_W=16)
// checked every cycle against a table-driven S-DES model plus literal vectors.
module tb_sdes_feistel_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       decrypt   [2];
    logic [7:0] k1        [2];
    logic [7:0] k2        [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic       busy      [2];
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    localparam int LAT [2] = '{3, 5};
    localparam logic [15:0] CNT_MASK [2] = '{16'h0003, 16'hFFFF};

    // Permutation tables, one hex digit per output position, position 1 first.
    localparam logic [31:0] T_IP  = 32'h26314857;
    localparam logic [31:0] T_IPI = 32'h41357286;
    localparam logic [31:0] T_EP  = 32'h41232341;
    localparam logic [31:0] T_P4  = 32'h24310000;
    localparam int S0 [4][4] = '{'{1,0,3,2}, '{3,2,1,0}, '{0,2,1,3}, '{3,1,3,2}};
    localparam int S1 [4][4] = '{'{0,1,2,3}, '{2,0,1,3}, '{3,0,1,0}, '{2,1,0,3}};

    always #5 clk = ~clk;

    sdes_feistel_core #(.SBOX_REG(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .decrypt(decrypt[0]), .k1(k1[0]), .k2(k2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .blk_count(cnt_a)
    );

    sdes_feistel_core #(.SBOX_REG(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .decrypt(decrypt[1]), .k1(k1[1]), .k2(k2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .blk_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] perm(input logic [7:0] d, input logic [31:0] tbl,
                                        input int n_out, input int n_in);
        logic [7:0] o;
        int src;
        o = '0;
        for (int j = 1; j <= n_out; j++) begin
            src = int'(tbl[31-4*(j-1) -: 4]);
            o[n_out-j] = d[n_in-src];
        end
        return o;
    endfunction

    function automatic logic [3:0] fk_model(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        logic [7:0] p;
        int a;
        int b;
        x = perm({4'b0, r}, T_EP, 8, 4) ^ k;
        a = S0[{x[7], x[4]}][{x[6], x[5]}];
        b = S1[{x[3], x[0]}][{x[2], x[1]}];
        p = perm({4'b0, a[1:0], b[1:0]}, T_P4, 4, 4);
        return p[3:0];
    endfunction

    function automatic logic [7:0] sdes_model(input logic [7:0] d, input logic [7:0] key1,
                                              input logic [7:0] key2, input logic dec);
        logic [7:0] b;
        logic [7:0] rk [2];
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] t;
        rk[0] = dec ? key2 : key1;
        rk[1] = dec ? key1 : key2;
        b = perm(d, T_IP, 8, 8);
        l = b[7:4];
        r = b[3:0];
        for (int rnd = 0; rnd < 2; rnd++) begin
            l = l ^ fk_model(r, rk[rnd]);
            if (rnd == 0) begin
                t = l; l = r; r = t;
            end
        end
        return perm({l, r}, T_IPI, 8, 8);
    endfunction

    function automatic logic [15:0] cnt_of(input int i);
        return (i == 0) ? {14'b0, cnt_a} : cnt_b;
    endfunction

    // ---------------- per-cycle compare process ----------------
    int         cyc = 0;
    logic       pending [2] = '{1'b0, 1'b0};
    logic       seen    [2] = '{1'b0, 1'b0};
    logic [7:0] exp_out [2];
    int         acc_cyc [2];
    logic [15:0] model_cnt [2] = '{16'd0, 16'd0};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pending[i]   = 1'b0;
                seen[i]      = 1'b0;
                model_cnt[i] = '0;
                check($sformatf("rst out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
                check($sformatf("rst in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
                check($sformatf("rst busy[%0d]", i), 32'(busy[i]), 32'd0);
                check($sformatf("rst out_data[%0d]", i), 32'(out_data[i]), 32'd0);
                check($sformatf("rst blk_count[%0d]", i), 32'(cnt_of(i)), 32'd0);
            end else begin
                check($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(!pending[i]));
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(pending[i]));
                check($sformatf("blk_count[%0d]", i), 32'(cnt_of(i)), 32'(model_cnt[i] & CNT_MASK[i]));
                if (out_valid[i]) begin
                    if (!pending[i]) begin
                        check($sformatf("spurious out_valid[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(exp_out[i]));
                        if (!seen[i]) begin
                            check($sformatf("latency[%0d]", i), 32'(cyc - acc_cyc[i]), 32'(LAT[i]));
                            seen[i] = 1'b1;
                        end
                        if (out_ready[i]) begin
                            pending[i]   = 1'b0;
                            seen[i]      = 1'b0;
                            model_cnt[i] = model_cnt[i] + 16'd1;
                        end
                    end
                end
                if (in_valid[i] && in_ready[i]) begin
                    pending[i] = 1'b1;
                    seen[i]    = 1'b0;
                    exp_out[i] = sdes_model(in_data[i], k1[i], k2[i], decrypt[i]);
                    acc_cyc[i] = cyc;
                end
            end
        end
    end

    // ---------------- drivers (all return 1 time unit after a rising edge) ----------------
    task automatic send(input int i, input logic [7:0] d, input logic [7:0] key1,
                        input logic [7:0] key2, input logic dec);
        logic ok;
        ok = 1'b0;
        in_data[i] = d; k1[i] = key1; k2[i] = key2; decrypt[i] = dec; in_valid[i] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("accept timeout[%0d]", i), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the inputs so any use outside the accept cycle shows up.
        in_valid[i] = 1'b0; in_data[i] = ~d; k1[i] = ~key1; k2[i] = ~key2; decrypt[i] = ~dec;
    endtask

    task automatic wait_out(input int i, input logic [7:0] exp, input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, " out_valid timeout"}, 32'd0, 32'd1);
        else     check(name, 32'(out_data[i]), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    localparam logic [7:0] PT = 8'b10010111;
    localparam logic [7:0] CT = 8'b00111000;
    localparam logic [7:0] KA = 8'b10100100;
    localparam logic [7:0] KB = 8'b01000011;
    localparam logic [1:0] WRAP_SEQ [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        logic [7:0] rd;
        logic [7:0] rk1;
        logic [7:0] rk2;
        logic       rdec;
        logic [7:0] rexp;

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; decrypt[i] = 1'b0;
            k1[i] = '0; k2[i] = '0; out_ready[i] = 1'b1;
        end
        rst = 1'b1;

        // Pin the model to the textbook vector.
        check("model encrypt", 32'(sdes_model(PT, KA, KB, 1'b0)), 32'(CT));
        check("model decrypt", 32'(sdes_model(CT, KA, KB, 1'b1)), 32'(PT));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1/2: encrypt then decrypt, SBOX_REG=0
        send(0, PT, KA, KB, 1'b0);
        wait_out(0, CT, "t1 encrypt");
        check("t1 blk_count", 32'(cnt_a), 32'd1);
        send(0, CT, KA, KB, 1'b1);
        wait_out(0, PT, "t2 decrypt");
        check("t2 blk_count", 32'(cnt_a), 32'd2);

        // 3: backpressure with a pending block held on the input
        out_ready[0] = 1'b0;
        send(0, PT, KA, KB, 1'b0);
        wait_out(0, CT, "t3 first");
        in_data[0] = CT; k1[0] = KA; k2[0] = KB; decrypt[0] = 1'b1; in_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("t3 hold out_data", 32'(out_data[0]), 32'(CT));
            check("t3 hold out_valid", 32'(out_valid[0]), 32'd1);
            check("t3 hold in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3 ready after release", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        check("t3 blk_count", 32'(cnt_a), 32'd3);
        wait_out(0, PT, "t3 second");
        check("t3 blk_count after", 32'(cnt_a), 32'd0);

        // 4: SBOX_REG=1 rerun
        send(1, PT, KA, KB, 1'b0);
        wait_out(1, CT, "t4 encrypt");
        check("t4 blk_count", 32'(cnt_b), 32'd1);
        send(1, CT, KA, KB, 1'b1);
        wait_out(1, PT, "t4 decrypt");
        check("t4 blk_count 2", 32'(cnt_b), 32'd2);

        // 5: reset while dut0 is in R2
        send(0, PT, KA, KB, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("t5 in_ready", 32'(in_ready[0]), 32'd1);
        check("t5 blk_count", 32'(cnt_a), 32'd0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("t5 no out_valid", 32'(out_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, CT, KA, KB, 1'b1);
        wait_out(0, PT, "t5 after reset");

        // 6: counter wrap on the 2-bit counter, random blocks
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            rd = 8'($urandom); rk1 = 8'($urandom); rk2 = 8'($urandom); rdec = 1'($urandom);
            rexp = sdes_model(rd, rk1, rk2, rdec);
            send(0, rd, rk1, rk2, rdec);
            wait_out(0, rexp, "t6 random");
            check("t6 blk_count", 32'(cnt_a), 32'(WRAP_SEQ[n]));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
